// File: rtl/val_change_logger_if.sv
// Bus bundle for val_change_logger: observed value input, record stream output, overflow flag.
// The master side is the surrounding environment and the slave side is the logger.
interface val_change_logger_if #(
  parameter int W    = 1,
  parameter int TS_W = 8
);
  logic [W-1:0]      in_val;
  logic              in_en;
  logic              out_valid;
  logic              out_ready;
  logic [TS_W+W-1:0] out_data;
  logic              ovf;

  modport master (
    output in_val, in_en, out_ready,
    input  out_valid, out_data, ovf
  );

  modport slave (
    input  in_val, in_en, out_ready,
    output out_valid, out_data, ovf
  );
endinterface

// File: rtl/val_change_logger.sv
// Hardware $monitor: time-stamps changes on a value bus and queues {ts, val} records in a FIFO.
// Optional feature macro VAL_CHG_LOG_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module val_change_logger #(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  val_change_logger_if.slave   bus
`ifdef VAL_CHG_LOG_DROP_CNT_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = TS_W + W;

  typedef enum logic {UNPRIMED, PRIMED} state_t;

  state_t            state_reg, state_next;
  logic [W-1:0]      prev_reg, prev_next;
  logic [TS_W-1:0]   ts_reg;
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic [REC_W-1:0]  entry_reg [DEPTH];
  logic              ovf_reg;

  logic push_req, full, empty, pop, push_ok, drop;

  // Change detector: the first enabled sample after reset is always logged.
  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    push_req   = 1'b0;
    if (bus.in_en) begin
      case (state_reg)
        UNPRIMED: begin
          push_req   = 1'b1;
          prev_next  = bus.in_val;
          state_next = PRIMED;
        end
        PRIMED: begin
          if (bus.in_val != prev_reg) begin
            push_req  = 1'b1;
            prev_next = bus.in_val;
          end
        end
        default: state_next = UNPRIMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= UNPRIMED;
      prev_reg  <= '0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ts_reg <= '0;
    else        ts_reg <= ts_reg + 1'b1;
  end

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
  assign pop     = !empty && bus.out_ready;
  // A pop frees the head slot at the same edge, so a full FIFO still accepts the push.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(i)))
          entry_reg[i] <= {ts_reg, bus.in_val};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    ovf_reg <= 1'b0;
    else if (drop) ovf_reg <= 1'b1;
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = entry_reg[rd_ptr_reg[AW-1:0]];
  assign bus.ovf       = ovf_reg;

`ifdef VAL_CHG_LOG_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != 8'hFF))
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_val_change_logger.sv
// Directed self-checking bench for val_change_logger (W=4, DEPTH=4, TS_W=8).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_val_change_logger;
  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int TS_W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  val_change_logger_if #(.W(W), .TS_W(TS_W)) bus();

`ifdef VAL_CHG_LOG_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  val_change_logger #(.W(W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VAL_CHG_LOG_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this returns the DUT is out of reset and ts is 0 in the current cycle.
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_en     = 1'b0;
    bus.in_val    = '0;
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic pop_one(output logic v, output logic [11:0] d);
    v = bus.out_valid;
    d = bus.out_data;
    $display("pop: valid=%b ts=%0d val=%h", v, d[11:4], d[3:0]);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_en     = 1'b1;
    bus.in_val    = 4'h7;
    bus.out_ready = 1'b0;
    step();
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    n_vec++;
    if (bus.out_data !== 12'h000) begin
      n_err++; $display("FAIL reset_data: got %h expected 000", bus.out_data);
    end
    n_vec++;
    if (bus.ovf !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf);
    end
`ifdef VAL_CHG_LOG_DROP_CNT_EN
    n_vec++;
    if (drop_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
    end
`endif
    bus.in_en  = 1'b0;
    bus.in_val = '0;
    rst_n      = 1'b1;
  endtask

  // Continues directly from test_reset: current cycle has ts=0.
  task automatic test_initial_print();
    logic v;
    logic [11:0] d;
    step(); step(); step();
    bus.in_en  = 1'b1;
    bus.in_val = 4'h1;
    step();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {8'd3, 4'h1}) begin
      n_err++; $display("FAIL init_record: got v=%b d=%h expected v=1 d=031", bus.out_valid, bus.out_data);
    end
    step(); step(); step();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {8'd3, 4'h1}) begin
      n_err++; $display("FAIL init_hold_stable: got v=%b d=%h expected v=1 d=031", bus.out_valid, bus.out_data);
    end
    pop_one(v, d);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL init_no_repeat: got out_valid=%b expected 0", bus.out_valid);
    end
    bus.in_en = 1'b0;
  endtask

  task automatic test_change_stream();
    logic v;
    logic [11:0] d;
    logic [3:0]  vals [4];
    logic [11:0] exp_q [3];
    vals  = '{4'h1, 4'h5, 4'h5, 4'h9};
    exp_q = '{{8'd2, 4'h1}, {8'd3, 4'h5}, {8'd5, 4'h9}};
    do_reset();
    step(); step();
    bus.in_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_val = vals[i];
      step();
    end
    bus.in_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop_one(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== exp_q[i]) begin
        n_err++; $display("FAIL stream_rec%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, exp_q[i]);
      end
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_empty: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_overflow();
    logic v;
    logic [11:0] d;
    do_reset();
    bus.in_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.in_val = 4'(i);
      step();
      if (i == 4) begin
        n_vec++;
        if (bus.ovf !== 1'b0) begin
          n_err++; $display("FAIL ovf_at_full: got %b expected 0", bus.ovf);
        end
      end
    end
    n_vec++;
    if (bus.ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %b expected 1", bus.ovf);
    end
`ifdef VAL_CHG_LOG_DROP_CNT_EN
    n_vec++;
    if (drop_cnt !== 8'd2) begin
      n_err++; $display("FAIL drop_cnt: got %0d expected 2", drop_cnt);
    end
`endif
    // Value 6 was dropped but still became the reference, so holding it logs nothing.
    step();
    bus.in_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pop_one(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== {8'(i), 4'(i + 1)}) begin
        n_err++; $display("FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, {8'(i), 4'(i + 1)});
      end
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL ovf_drained_empty: got out_valid=%b expected 0", bus.out_valid);
    end
    bus.in_en  = 1'b1;
    bus.in_val = 4'h7;
    step();
    bus.in_en = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {8'd11, 4'h7}) begin
      n_err++; $display("FAIL ovf_after_drop: got v=%b d=%h expected v=1 d=0b7", bus.out_valid, bus.out_data);
    end
    n_vec++;
    if (bus.ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_still_set: got %b expected 1", bus.ovf);
    end
  endtask

  task automatic test_full_pop();
    logic v;
    logic [11:0] d;
    logic [11:0] exp_q [4];
    exp_q = '{{8'd1, 4'h2}, {8'd2, 4'h3}, {8'd3, 4'h4}, {8'd4, 4'h5}};
    do_reset();
    bus.in_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_val = 4'(i);
      step();
    end
    bus.in_val    = 4'h5;
    bus.out_ready = 1'b1;
    step();
    bus.in_en     = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.ovf !== 1'b0) begin
      n_err++; $display("FAIL fullpop_ovf: got %b expected 0", bus.ovf);
    end
    for (int i = 0; i < 4; i++) begin
      pop_one(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== exp_q[i]) begin
        n_err++; $display("FAIL fullpop_rec%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, exp_q[i]);
      end
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL fullpop_empty: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_ts_wrap();
    logic v;
    logic [11:0] d;
    logic [11:0] exp_q [3];
    exp_q = '{{8'd254, 4'h1}, {8'd255, 4'h2}, {8'd0, 4'h3}};
    do_reset();
    for (int i = 0; i < 254; i++) step();
    bus.in_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_val = 4'(i);
      step();
    end
    bus.in_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop_one(v, d);
      n_vec++;
      if (v !== 1'b1 || d !== exp_q[i]) begin
        n_err++; $display("FAIL wrap_rec%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_en     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_val = 4'(i + 1);
      step();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {8'(i), 4'(i + 1)}) begin
        n_err++; $display("FAIL b2b_rec%0d: got v=%b d=%h expected v=1 d=%h", i, bus.out_valid, bus.out_data, {8'(i), 4'(i + 1)});
      end
    end
    bus.in_en = 1'b0;
    step();
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_empty: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic v;
    logic [11:0] d;
    do_reset();
    bus.in_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_val = 4'(i);
      step();
    end
    bus.in_en = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_queued: got out_valid=%b expected 1", bus.out_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++; $display("FAIL mid_flushed: got v=%b ovf=%b expected v=0 ovf=0", bus.out_valid, bus.ovf);
    end
    // Value 0 matches the reset reference, so only an unprimed logger records it.
    bus.in_en  = 1'b1;
    bus.in_val = 4'h0;
    step();
    bus.in_en = 1'b0;
    pop_one(v, d);
    n_vec++;
    if (v !== 1'b1 || d !== {8'd0, 4'h0}) begin
      n_err++; $display("FAIL mid_initial: got v=%b d=%h expected v=1 d=000", v, d);
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_empty: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_en     = 1'b0;
    bus.in_val    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_initial_print();
    test_change_stream();
    test_overflow();
    test_full_pop();
    test_ts_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
